// File: rtl/mac_feeder_pkg.sv
// Shared encodings for the MAC column feeder: FSM states, column instructions
// and the tag carried alongside each SRAM read.
package mac_feeder_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_LOAD = 2'd1;
    localparam logic [1:0] TAG_EXEC = 2'd2;

    localparam int DRAIN_CYCLES = 2;

    function automatic logic [1:0] tag_to_inst(input logic [1:0] tag);
        case (tag)
            TAG_LOAD: return INST_LOAD;
            TAG_EXEC: return INST_EXEC;
            default:  return INST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/zero_flag_gen.sv
// Per-element equal-to-zero detector for a packed vector of pr elements of bw bits.
module zero_flag_gen #(
    parameter int bw = 8,
    parameter int pr = 8
) (
    input  logic [pr*bw-1:0] vec,
    output logic [pr-1:0]    zero
);

    always_comb begin
        zero = '0;
        for (int i = 0; i < pr; i++) begin
            zero[i] = (vec[bw*i +: bw] == '0);
        end
    end

endmodule

// File: rtl/mac_zero_feeder.sv
// Streams key vectors (load) then query vectors (execute) from a 1-cycle SRAM
// into MAC column 0, with per-element zero flags aligned to each vector.
module mac_zero_feeder
    import mac_feeder_pkg::*;
#(
    parameter int bw     = 8,
    parameter int pr     = 8,
    parameter int col    = 8,
    parameter int addr_w = 11,
    parameter int cnt_w  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addr_w-1:0]   key_base,
    input  logic [addr_w-1:0]   q_base,
    input  logic [cnt_w-1:0]    num_q,
    output logic                mem_rd,
    output logic [addr_w-1:0]   mem_addr,
    input  logic [pr*bw-1:0]    mem_rdata,
    output logic [pr*bw-1:0]    q_out,
    output logic [pr-1:0]       k_zero,
    output logic [pr-1:0]       q_zero,
    output logic [1:0]          o_inst,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = (cnt_w > $clog2(col) + 1) ? cnt_w : $clog2(col) + 1;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [addr_w-1:0] key_base_q, key_base_d;
    logic [addr_w-1:0] q_base_q, q_base_d;
    logic [cnt_w-1:0]  num_q_q, num_q_d;
    logic [1:0]        issue_tag;

    logic [1:0]        tag_q, tag_d;
    logic [1:0]        inst_q, inst_d;
    logic [pr*bw-1:0]  q_out_q, q_out_d;
    logic [pr-1:0]     k_zero_q, k_zero_d;
    logic [pr-1:0]     q_zero_q, q_zero_d;
    logic [pr-1:0]     rd_zero;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_base_d = key_base_q;
        q_base_d   = q_base_q;
        num_q_d    = num_q_q;
        issue_tag  = TAG_NONE;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_base_d = key_base;
                    q_base_d   = q_base;
                    num_q_d    = num_q;
                    cnt_d      = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mem_rd    = 1'b1;
                mem_addr  = key_base_q + addr_w'(cnt_q);
                issue_tag = TAG_LOAD;
                if (cnt_q == CNT_W'(col - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                cnt_d   = '0;
                state_d = (num_q_q != '0) ? ST_EXEC : ST_DRAIN;
            end
            ST_EXEC: begin
                mem_rd    = 1'b1;
                mem_addr  = q_base_q + addr_w'(cnt_q);
                issue_tag = TAG_EXEC;
                if (cnt_q + CNT_W'(1) == CNT_W'(num_q_q)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                // Lets the last two in-flight reads reach the outputs
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    zero_flag_gen #(
        .bw (bw),
        .pr (pr)
    ) u_zero_flag_gen (
        .vec  (mem_rdata),
        .zero (rd_zero)
    );

    // tag_q marks the cycle whose mem_rdata belongs to an issued read
    always_comb begin
        tag_d    = issue_tag;
        inst_d   = tag_to_inst(tag_q);
        q_out_d  = q_out_q;
        k_zero_d = '0;
        q_zero_d = '0;
        if (tag_q != TAG_NONE) begin
            q_out_d = mem_rdata;
        end
        if (tag_q == TAG_LOAD) begin
            k_zero_d = rd_zero;
        end
        if (tag_q == TAG_EXEC) begin
            q_zero_d = rd_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            key_base_q <= '0;
            q_base_q   <= '0;
            num_q_q    <= '0;
            tag_q      <= TAG_NONE;
            inst_q     <= INST_IDLE;
            q_out_q    <= '0;
            k_zero_q   <= '0;
            q_zero_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_base_q <= key_base_d;
            q_base_q   <= q_base_d;
            num_q_q    <= num_q_d;
            tag_q      <= tag_d;
            inst_q     <= inst_d;
            q_out_q    <= q_out_d;
            k_zero_q   <= k_zero_d;
            q_zero_q   <= q_zero_d;
        end
    end

    assign q_out  = q_out_q;
    assign k_zero = k_zero_q;
    assign q_zero = q_zero_q;
    assign o_inst = inst_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule

// File: doc/mac_zero_feeder.md
Name: mac_zero_feeder

Overview:
- Upstream driver for a row of gated MAC columns.
- Reads key vectors, then query vectors, from a 1-cycle-latency SRAM.
- Generates per-element zero flags for each vector and drives the column's q_in / k_zero / q_zero / i_inst stream: a load phase, one idle cycle, then an execute phase.
- Sits between the activation/weight SRAM and column 0 of the MAC array. Downstream columns receive the stream through their own pipelined instruction and data forwarding.

Parameters:
- bw, 8, element width in bits.
- pr, 8, elements per vector.
- col, 8, number of key vectors per load phase (one per MAC column).
- addr_w, 11, SRAM address width.
- cnt_w, 8, width of the query-count input.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to run one load+execute sequence; sampled only in IDLE.
- key_base  input  addr_w  first key vector address; sampled with start.
- q_base  input  addr_w  first query vector address; sampled with start.
- num_q  input  cnt_w  number of query vectors to execute; sampled with start; 0 is legal.
- mem_rd  output  1  SRAM read enable.
- mem_addr  output  addr_w  SRAM read address.
- mem_rdata  input  pr*bw  SRAM data, valid the cycle after mem_rd.
- q_out  output  pr*bw  vector to the MAC column (element i at bits [bw*(i+1)-1:bw*i]).
- k_zero  output  pr  per-element zero flags; nonzero only while o_inst==2'b01.
- q_zero  output  pr  per-element zero flags; nonzero only while o_inst==2'b10.
- o_inst  output  2  [1] execute, [0] load; never 2'b11.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset: all outputs 0 (mem_rd, mem_addr, q_out, k_zero, q_zero, o_inst, busy, done). State = IDLE. Address counters cleared. Pipeline valid bits cleared. Reset mid-sequence aborts immediately: no further o_inst pulses and no done.
- FSM states: IDLE, LOAD, GAP, EXEC, DRAIN, DONE.
  - IDLE: if start, latch key_base, q_base and num_q, then go to LOAD.
  - LOAD: mem_rd=1, mem_addr = key_base + k with k = 0..col-1, one per cycle. After col issues, go to GAP.
  - GAP: exactly 1 cycle, mem_rd=0. Go to EXEC if num_q != 0, else to DRAIN.
  - EXEC: mem_rd=1, mem_addr = q_base + j with j = 0..num_q-1. After the last issue, go to DRAIN.
  - DRAIN: 2 cycles, mem_rd=0, flushes the output pipeline. Then go to DONE.
  - DONE: done=1 and busy=1 for 1 cycle, then IDLE. busy=0 in IDLE.
- Address arithmetic wraps modulo 2^addr_w.
- start while not IDLE is ignored.
- Output pipeline: an issue in cycle t produces output in cycle t+2. The data returns at t+1 and is registered at the end of t+1.
  - A 2-entry tag pipeline (none/load/exec) travels with the issues.
  - o_inst = 2'b01 for load tags, 2'b10 for exec tags, 2'b00 otherwise.
- Output alignment:
  - q_out is the registered mem_rdata for a tagged cycle. q_out holds its previous value when o_inst==0.
  - Zero flag: flag[i] = (element i == 0), registered in the same cycle as q_out. It is routed to k_zero on load tags and to q_zero on exec tags. The other flag bus is 0.
- Sequence timeline (start accepted in cycle 0):
  - o_inst=01 in cycles 3..col+2.
  - o_inst=00 in cycle col+3.
  - o_inst=10 in cycles col+4..col+3+num_q.
  - done in cycle col+4+num_q. With num_q=0, done is in cycle col+4.
- Exactly col load cycles per sequence, always contiguous. The column's load counter depends on this.

Decomposition:
- Shared package mac_feeder_pkg:
  - State enum (IDLE, LOAD, GAP, EXEC, DRAIN, DONE).
  - Instruction constants INST_IDLE=2'b00, INST_LOAD=2'b01, INST_EXEC=2'b10.
  - Pipeline tag encoding.
- One sub-module: zero_flag_gen, a combinational pr-element equal-to-zero detector, parameterised on bw and pr.

Test Plan:
- Basic: col=8, key_base=0, q_base=16, num_q=4, SRAM word a holds bytes {a+1,...} -> mem_addr 0..7 then 16..19; o_inst=01 in cycles 3..10, 00 in cycle 11, 10 in cycles 12..15; done in cycle 16 only; q_out matches SRAM words in order.
- Zero flags: key word 3 = 0x00FF00FF00FF00FF, query word 1 = 0 -> k_zero=8'b10101010 on the 4th load cycle with q_zero=0; q_zero=8'hFF on the 2nd exec cycle with k_zero=0.
- num_q=0 -> exactly 8 load cycles, 1 idle, no o_inst=10, done in cycle 12.
- Address wrap: addr_w=11, key_base=2044 -> mem_addr 2044..2047, 0..3.
- Start while busy: start pulsed at cycle 5 of a sequence -> ignored; a single done; addresses unchanged.
- Reset at cycle 6 (mid-LOAD) -> next cycle all outputs 0, no done; a fresh start afterwards produces the full basic sequence.
